// File: rtl/func_pkg.sv
// func_pkg: shared types and constants for the func_ctrl sequencer.
//   A_W / B_W          operand widths for the a^3 + isqrt(b) function unit
//   Y_W                result width (255^3 + 15 fits in 24 bits)
//   TIMEOUT_CYCLES_DEF default wait budget on the function unit
//   func_state_e       controller state encoding
package func_pkg;

  localparam int A_W = 8;
  localparam int B_W = 8;
  localparam int Y_W = 24;
  localparam int TIMEOUT_CYCLES_DEF = 255;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ARM       = 3'd1,
    ST_START     = 3'd2,
    ST_WAIT_BUSY = 3'd3,
    ST_WAIT_DONE = 3'd4,
    ST_RESP      = 3'd5
  } func_state_e;

endpackage

// File: rtl/func_ctrl_tmr.sv
// func_ctrl_tmr: timeout counter for the function-unit wait phase.
//   clk_i, rst_i  clock, asynchronous active-high reset
//   clr           zero the count (asserted on the cycle before waiting starts)
//   en            count this cycle (high while waiting on the unit)
//   expired       high on the waiting cycle whose increment brings the count
//                 to TIMEOUT_CYCLES, so a wait lasts at most TIMEOUT_CYCLES cycles
module func_ctrl_tmr
  import func_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // The controller leaves the wait states when this fires, so the count
  // never advances past TIMEOUT_CYCLES and cannot wrap.
  assign expired = en && (cnt_q == CNT_LAST);

endmodule

// File: rtl/func_ctrl.sv
// func_ctrl: handshake sequencer in front of a function unit computing
// a^3 + isqrt(b). Accepts one operand pair, waits for the unit to be free,
// pulses start, tracks the unit busy flag, and holds the result (or a
// timeout indication) until the host takes it.
//   clk_i, rst_i                       clock, asynchronous active-high reset
//   req_valid_i, req_a_i, req_b_i      host request
//   req_ready_o                        request accepted this cycle (IDLE)
//   fu_start_o, fu_a_o, fu_b_o         start pulse and held operands to the unit
//   fu_busy_i, fu_y_i                  unit busy flag and result
//   rsp_valid_o, rsp_ready_i           response handshake
//   rsp_y_o, rsp_timeout_o             captured result, abort flag
//   busy_o                             controller not idle
//
// state        | meaning
// IDLE         | waiting for a host request
// ARM          | operands latched, waiting for the unit to finish older work
// START        | one-cycle start pulse to the unit
// WAIT_BUSY    | waiting for the unit to raise busy
// WAIT_DONE    | waiting for the unit to drop busy
// RESP         | response held until the host accepts it
module func_ctrl
  import func_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           req_valid_i,
  input  logic [A_W-1:0] req_a_i,
  input  logic [B_W-1:0] req_b_i,
  output logic           req_ready_o,
  output logic           fu_start_o,
  output logic [A_W-1:0] fu_a_o,
  output logic [B_W-1:0] fu_b_o,
  input  logic           fu_busy_i,
  input  logic [Y_W-1:0] fu_y_i,
  output logic           rsp_valid_o,
  input  logic           rsp_ready_i,
  output logic [Y_W-1:0] rsp_y_o,
  output logic           rsp_timeout_o,
  output logic           busy_o
);

  func_state_e state_q, state_d;

  logic req_acc;
  logic cap_done;
  logic cap_timeout;
  logic tmr_clr;
  logic tmr_en;
  logic tmr_expired;

  func_ctrl_tmr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_tmr (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .expired (tmr_expired)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    req_acc     = 1'b0;
    cap_done    = 1'b0;
    cap_timeout = 1'b0;
    req_ready_o = 1'b0;
    fu_start_o  = 1'b0;
    rsp_valid_o = 1'b0;
    busy_o      = 1'b1;
    tmr_clr     = 1'b0;
    tmr_en      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        req_ready_o = 1'b1;
        busy_o      = 1'b0;
        if (req_valid_i) begin
          req_acc = 1'b1;
          state_d = ST_ARM;
        end
      end
      ST_ARM: begin
        if (!fu_busy_i) state_d = ST_START;
      end
      ST_START: begin
        fu_start_o = 1'b1;
        tmr_clr    = 1'b1;
        state_d    = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        tmr_en = 1'b1;
        // Busy rising is not a completion, so an expired budget wins here.
        if (tmr_expired) begin
          cap_timeout = 1'b1;
          state_d     = ST_RESP;
        end else if (fu_busy_i) begin
          state_d = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        tmr_en = 1'b1;
        // A completion on the final budget cycle is still a good result.
        if (!fu_busy_i) begin
          cap_done = 1'b1;
          state_d  = ST_RESP;
        end else if (tmr_expired) begin
          cap_timeout = 1'b1;
          state_d     = ST_RESP;
        end
      end
      ST_RESP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fu_a_o        <= '0;
      fu_b_o        <= '0;
      rsp_y_o       <= '0;
      rsp_timeout_o <= 1'b0;
    end else begin
      if (req_acc) begin
        fu_a_o <= req_a_i;
        fu_b_o <= req_b_i;
      end
      if (cap_done) begin
        rsp_y_o       <= fu_y_i;
        rsp_timeout_o <= 1'b0;
      end else if (cap_timeout) begin
        rsp_y_o       <= '0;
        rsp_timeout_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_func_ctrl.sv
// tb_func_ctrl: self-checking bench for func_ctrl with a cycle-stepped
// function-unit model and a timing/result reference model.
`timescale 1ns/1ps
module tb_func_ctrl;
  import func_pkg::*;

  localparam int T = 255;

  logic           clk_i = 1'b0;
  logic           rst_i;
  logic           req_valid_i;
  logic [A_W-1:0] req_a_i;
  logic [B_W-1:0] req_b_i;
  logic           req_ready_o;
  logic           fu_start_o;
  logic [A_W-1:0] fu_a_o;
  logic [B_W-1:0] fu_b_o;
  logic           fu_busy_i;
  logic [Y_W-1:0] fu_y_i;
  logic           rsp_valid_o;
  logic           rsp_ready_i;
  logic [Y_W-1:0] rsp_y_o;
  logic           rsp_timeout_o;
  logic           busy_o;

  always #5 clk_i = ~clk_i;

  func_ctrl #(.TIMEOUT_CYCLES(T)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .req_valid_i   (req_valid_i),
    .req_a_i       (req_a_i),
    .req_b_i       (req_b_i),
    .req_ready_o   (req_ready_o),
    .fu_start_o    (fu_start_o),
    .fu_a_o        (fu_a_o),
    .fu_b_o        (fu_b_o),
    .fu_busy_i     (fu_busy_i),
    .fu_y_i        (fu_y_i),
    .rsp_valid_o   (rsp_valid_o),
    .rsp_ready_i   (rsp_ready_i),
    .rsp_y_o       (rsp_y_o),
    .rsp_timeout_o (rsp_timeout_o),
    .busy_o        (busy_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, wanted %0d", name, act, exp);
    end
  endtask

  // Reference result: a cubed plus the integer square root of b.
  function automatic logic [Y_W-1:0] ref_y(input logic [7:0] a, input logic [7:0] b);
    int r;
    int cube;
    r = 0;
    while ((r + 1) * (r + 1) <= int'(b)) r++;
    cube = int'(a) * int'(a) * int'(a);
    return Y_W'(cube + r);
  endfunction

  typedef struct {
    logic [7:0]     a;
    logic [7:0]     b;
    int             pre;   // cycles the unit is still busy when the request arrives
    int             d;     // cycles after start before the unit raises busy
    int             l;     // cycles the unit stays busy
    int             hold;  // cycles the host delays rsp_ready_i
    logic [Y_W-1:0] exp_y;
    logic           exp_to;
  } vec_t;

  // One full transaction. Timing expectations: start appears max(pre,1)+1
  // cycles after the handshake cycle; the response appears one cycle after
  // min(d+l+1, T) waiting cycles; a timeout happens when d+l+1 exceeds T.
  task automatic run_txn(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input int pre, input int d, input int l, input int hold,
                         input logic [Y_W-1:0] exp_y, input logic exp_to);
    int exp_start, exp_resp, start_at, resp_at, rel, starts, wait_n;
    logic ok;
    logic [Y_W-1:0] y_seen;
    logic to_seen;
    exp_start = ((pre > 1) ? pre : 1) + 1;
    wait_n    = (d + l + 1 < T) ? (d + l + 1) : T;
    exp_resp  = exp_start + wait_n + 1;
    start_at  = -1;
    resp_at   = -1;
    starts    = 0;
    ok        = 1'b1;

    check({tag, "/req_ready_idle"}, int'(req_ready_o), 1);
    req_valid_i = 1'b1;
    req_a_i     = a;
    req_b_i     = b;
    fu_busy_i   = (pre > 0);
    fu_y_i      = Y_W'($urandom);
    rsp_ready_i = 1'b0;

    for (int cyc = 1; cyc <= T + 40 && resp_at < 0; cyc++) begin
      @(posedge clk_i); #1;
      // Keep offering junk: it must be ignored outside IDLE.
      req_valid_i = 1'b1;
      req_a_i     = 8'($urandom);
      req_b_i     = 8'($urandom);
      rsp_ready_i = 1'($urandom);
      if (fu_start_o) begin
        starts++;
        if (start_at < 0) start_at = cyc;
      end
      if (start_at >= 0 && (fu_a_o != a || fu_b_o != b)) ok = 1'b0;
      if (rsp_valid_o) resp_at = cyc;
      if (start_at < 0) begin
        fu_busy_i = (cyc < pre);
      end else begin
        rel       = cyc - start_at;
        fu_busy_i = (rel > d) && (rel <= d + l);
        fu_y_i    = (rel > d + l) ? ref_y(a, b) : Y_W'($urandom);
      end
    end
    rsp_ready_i = 1'b0;

    check({tag, "/start_cycle"}, start_at, exp_start);
    check({tag, "/start_count"}, starts, 1);
    check({tag, "/operands_held"}, int'(ok), 1);
    check({tag, "/resp_cycle"}, resp_at, exp_resp);
    check({tag, "/rsp_y"}, int'(rsp_y_o), int'(exp_y));
    check({tag, "/rsp_timeout"}, int'(rsp_timeout_o), int'(exp_to));
    check({tag, "/req_ready_resp"}, int'(req_ready_o), 0);

    y_seen  = rsp_y_o;
    to_seen = rsp_timeout_o;
    ok      = 1'b1;
    for (int h = 0; h < hold; h++) begin
      fu_y_i      = Y_W'($urandom);
      fu_busy_i   = 1'($urandom);
      req_valid_i = 1'b1;
      req_a_i     = 8'($urandom);
      @(posedge clk_i); #1;
      if (!rsp_valid_o || rsp_y_o != y_seen || rsp_timeout_o != to_seen ||
          req_ready_o || fu_start_o || !busy_o) ok = 1'b0;
    end
    check({tag, "/resp_hold_stable"}, int'(ok), 1);

    req_valid_i = 1'b0;
    fu_busy_i   = 1'b0;
    rsp_ready_i = 1'b1;
    @(posedge clk_i); #1;
    rsp_ready_i = 1'b0;
    check({tag, "/rsp_valid_after_accept"}, int'(rsp_valid_o), 0);
    check({tag, "/idle_after_accept"}, int'(req_ready_o && !busy_o), 1);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, wanted completion");
    $fatal(1, "watchdog");
  end

  vec_t vecs[9];

  initial begin
    logic [7:0] ra, rb;
    int rpre, rd, rl, rh;
    logic rto;

    vecs[0] = '{8'd3,   8'd16,  0, 0,    3,   0,  24'd31,       1'b0};
    vecs[1] = '{8'd255, 8'd255, 0, 2,    4,   1,  24'd16581390, 1'b0};
    vecs[2] = '{8'd10,  8'd0,   0, 1000, 1,   2,  24'd0,        1'b1};
    vecs[3] = '{8'd7,   8'd100, 0, 1,    2,   10, 24'd353,      1'b0};
    vecs[4] = '{8'd1,   8'd1,   5, 0,    2,   0,  24'd2,        1'b0};
    vecs[5] = '{8'd4,   8'd50,  0, 100,  154, 0,  24'd71,       1'b0};
    vecs[6] = '{8'd5,   8'd5,   0, 100,  155, 1,  24'd0,        1'b1};
    vecs[7] = '{8'd0,   8'd0,   1, 1,    1,   0,  24'd0,        1'b0};
    vecs[8] = '{8'd9,   8'd9,   0, 254,  1,   0,  24'd0,        1'b1};

    rst_i       = 1'b1;
    req_valid_i = 1'b0;
    req_a_i     = '0;
    req_b_i     = '0;
    fu_busy_i   = 1'b0;
    fu_y_i      = '0;
    rsp_ready_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    check("reset/outputs_zero",
          int'({fu_start_o, fu_a_o, fu_b_o, rsp_y_o, rsp_valid_o, rsp_timeout_o, busy_o} == '0), 1);
    check("reset/req_ready", int'(req_ready_o), 1);
    rst_i = 1'b0;
    @(posedge clk_i); #1;

    for (int i = 0; i < 9; i++) begin
      run_txn($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].pre, vecs[i].d,
              vecs[i].l, vecs[i].hold, vecs[i].exp_y, vecs[i].exp_to);
    end

    for (int i = 0; i < 20; i++) begin
      ra   = 8'($urandom);
      rb   = 8'($urandom);
      rpre = $urandom_range(0, 3);
      rd   = $urandom_range(0, 4);
      rl   = $urandom_range(1, 6);
      rh   = $urandom_range(0, 3);
      if ($urandom_range(0, 4) == 0) rd = $urandom_range(248, 300);
      rto = (rd + rl + 1 > T);
      run_txn($sformatf("rnd%0d", i), ra, rb, rpre, rd, rl, rh,
              rto ? '0 : ref_y(ra, rb), rto);
    end

    // Reset in the middle of WAIT_DONE, with a nonzero result still held.
    run_txn("pre_rst", 8'd3, 8'd16, 0, 0, 1, 0, 24'd31, 1'b0);
    req_valid_i = 1'b1;
    req_a_i     = 8'd200;
    req_b_i     = 8'd100;
    fu_busy_i   = 1'b0;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    @(posedge clk_i); #1;
    check("midrst/start_pulse", int'(fu_start_o), 1);
    fu_busy_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    check("midrst/in_wait", int'(busy_o && !rsp_valid_o && fu_a_o == 8'd200), 1);
    #2;
    rst_i = 1'b1;
    #1;
    check("midrst/outputs_zero",
          int'({fu_start_o, fu_a_o, fu_b_o, rsp_y_o, rsp_valid_o, rsp_timeout_o, busy_o} == '0), 1);
    fu_busy_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    @(posedge clk_i); #1;
    check("midrst/no_response", int'(rsp_valid_o), 0);
    run_txn("post_rst", 8'd2, 8'd9, 0, 0, 2, 0, 24'd11, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
